// File: rtl/life_engine_if.sv
// Command, edit and status signals of the Game-of-Life engine.
// The engine sits on the slave side; the controller drives the master side.
interface life_engine_if #(
   parameter int unsigned LOG_W = 4,
   parameter int unsigned LOG_H = 3
);
   localparam int unsigned AW = LOG_W + LOG_H;

   logic          cmd_valid;
   logic [1:0]    cmd_op;
   logic          cmd_ready;
   logic          wrap;
   logic [8:0]    birth_mask;
   logic [8:0]    survive_mask;
   logic          rand_bit;
   logic [AW-1:0] rd_addr;
   logic          rd_data;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic          wr_data;
   logic          busy;
   logic          done;
   logic [15:0]   generation;
   logic [AW:0]   pop_count;

   modport master (
      output cmd_valid, cmd_op, wrap, birth_mask, survive_mask, rand_bit,
             rd_addr, wr_en, wr_addr, wr_data,
      input  cmd_ready, rd_data, busy, done, generation, pop_count
   );

   modport slave (
      input  cmd_valid, cmd_op, wrap, birth_mask, survive_mask, rand_bit,
             rd_addr, wr_en, wr_addr, wr_data,
      output cmd_ready, rd_data, busy, done, generation, pop_count
   );
endinterface

// File: rtl/life_engine.sv
// Double-banked cellular automaton engine: seeds or clears the board, or computes
// one generation cell-by-cell (8 neighbour reads, 1 commit), then swaps banks.
module life_engine #(
   parameter int unsigned LOG_W = 4,
   parameter int unsigned LOG_H = 3
) (
   input  logic         clk,
   input  logic         reset,
   life_engine_if.slave bus
);
   localparam int unsigned W  = 1 << LOG_W;
   localparam int unsigned H  = 1 << LOG_H;
   localparam int unsigned N  = W * H;
   localparam int unsigned AW = LOG_W + LOG_H;

   typedef enum logic [2:0] {
      S_IDLE, S_SEED, S_COUNT, S_COMMIT, S_FLIP
   } state_t;

   state_t        r_state;
   logic          r_cur;
   logic [N-1:0]  r_bank_a;
   logic [N-1:0]  r_bank_b;
   logic [AW-1:0] r_idx;
   logic [2:0]    r_nb;
   logic [3:0]    r_count;
   logic          r_wrap;
   logic [8:0]    r_birth;
   logic [8:0]    r_survive;
   logic          r_rand_op;
   logic [AW:0]   r_acc;
   logic          r_busy;
   logic          r_done;
   logic [15:0]   r_gen;
   logic [AW:0]   r_pop;

   logic [N-1:0]  w_cur_bank;
   logic          w_last;
   logic          w_seed_bit;
   logic [LOG_W:0] w_dx;
   logic [LOG_H:0] w_dy;
   logic [LOG_W:0] w_nx;
   logic [LOG_H:0] w_ny;
   logic          w_nb_oob;
   logic [AW-1:0] w_nb_addr;
   logic          w_nb_live;
   logic          w_self;
   logic          w_next;
   logic          w_we;
   logic          w_wsel;
   logic [AW-1:0] w_waddr;
   logic          w_wdata;

   assign w_cur_bank = r_cur ? r_bank_b : r_bank_a;
   assign w_last     = (r_idx == AW'(N - 1));
   assign w_seed_bit = r_rand_op & bus.rand_bit;

   // Neighbour offsets as (dx, dy); -1 is all-ones in the extended coordinate
   always_comb begin
      w_dx = '0;
      w_dy = '0;
      case (r_nb)
         3'd0: begin w_dx = '1;                w_dy = (LOG_H+1)'(1); end
         3'd1: begin w_dx = '0;                w_dy = (LOG_H+1)'(1); end
         3'd2: begin w_dx = (LOG_W+1)'(1);     w_dy = (LOG_H+1)'(1); end
         3'd3: begin w_dx = '1;                w_dy = '0;            end
         3'd4: begin w_dx = (LOG_W+1)'(1);     w_dy = '0;            end
         3'd5: begin w_dx = '1;                w_dy = '1;            end
         3'd6: begin w_dx = '0;                w_dy = '1;            end
         default: begin w_dx = (LOG_W+1)'(1);  w_dy = '1;            end
      endcase
   end

   // The extra top bit flags a step off either edge; the low bits already hold the wrapped coordinate
   assign w_nx      = {1'b0, r_idx[LOG_W-1:0]} + w_dx;
   assign w_ny      = {1'b0, r_idx[AW-1:LOG_W]} + w_dy;
   assign w_nb_oob  = w_nx[LOG_W] | w_ny[LOG_H];
   assign w_nb_addr = {w_ny[LOG_H-1:0], w_nx[LOG_W-1:0]};
   assign w_nb_live = w_cur_bank[w_nb_addr] & (r_wrap | ~w_nb_oob);

   assign w_self = w_cur_bank[r_idx];
   assign w_next = w_self ? r_survive[r_count] : r_birth[r_count];

   // Single bank write port shared by host edits, seeding and commit
   always_comb begin
      w_we    = 1'b0;
      w_wsel  = r_cur;
      w_waddr = bus.wr_addr;
      w_wdata = bus.wr_data;
      case (r_state)
         S_IDLE: w_we = bus.wr_en;
         S_SEED: begin
            w_we    = 1'b1;
            w_waddr = r_idx;
            w_wdata = w_seed_bit;
         end
         S_COMMIT: begin
            w_we    = 1'b1;
            w_wsel  = ~r_cur;
            w_waddr = r_idx;
            w_wdata = w_next;
         end
         default: w_we = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bank_a <= '0;
         r_bank_b <= '0;
      end else if (w_we) begin
         if (w_wsel) r_bank_b[w_waddr] <= w_wdata;
         else        r_bank_a[w_waddr] <= w_wdata;
      end
   end

   // Command sequencer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cur     <= 1'b0;
         r_idx     <= '0;
         r_nb      <= '0;
         r_count   <= '0;
         r_wrap    <= 1'b0;
         r_birth   <= '0;
         r_survive <= '0;
         r_rand_op <= 1'b0;
         r_acc     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_gen     <= '0;
         r_pop     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  r_wrap    <= bus.wrap;
                  r_birth   <= bus.birth_mask;
                  r_survive <= bus.survive_mask;
                  r_idx     <= '0;
                  r_nb      <= '0;
                  r_count   <= '0;
                  r_acc     <= '0;
                  case (bus.cmd_op)
                     2'd0, 2'd1: begin
                        r_rand_op <= bus.cmd_op[0];
                        r_state   <= S_SEED;
                        r_busy    <= 1'b1;
                     end
                     2'd2: begin
                        r_state <= S_COUNT;
                        r_busy  <= 1'b1;
                     end
                     default: r_done <= 1'b1;
                  endcase
               end
            end
            S_SEED: begin
               r_acc <= r_acc + (AW+1)'(w_seed_bit);
               if (w_last) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_gen   <= '0;
                  r_pop   <= r_acc + (AW+1)'(w_seed_bit);
               end else begin
                  r_idx <= r_idx + AW'(1);
               end
            end
            S_COUNT: begin
               r_count <= r_count + 4'(w_nb_live);
               r_nb    <= r_nb + 3'd1;
               if (r_nb == 3'd7) r_state <= S_COMMIT;
            end
            S_COMMIT: begin
               r_acc <= r_acc + (AW+1)'(w_next);
               if (w_last) begin
                  r_state <= S_FLIP;
               end else begin
                  r_idx   <= r_idx + AW'(1);
                  r_nb    <= '0;
                  r_count <= '0;
                  r_state <= S_COUNT;
               end
            end
            S_FLIP: begin
               r_cur   <= ~r_cur;
               r_gen   <= r_gen + 16'd1;
               r_pop   <= r_acc;
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cmd_ready  = ~r_busy;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.generation = r_gen;
   assign bus.pop_count  = r_pop;
   assign bus.rd_data    = w_cur_bank[bus.rd_addr];

endmodule

// File: tb/tb_life_engine.sv
// Scoreboarded bench for life_engine: commands push expected results, a monitor
// checks them at each done pulse against a plain-arithmetic Life model.
module tb_life_engine;
   localparam int LOG_W = 4;
   localparam int LOG_H = 3;
   localparam int W  = 1 << LOG_W;
   localparam int H  = 1 << LOG_H;
   localparam int N  = W * H;
   localparam int AW = LOG_W + LOG_H;

   typedef struct {
      int          len;
      logic [15:0] gen;
      logic [AW:0] pop;
      logic [N-1:0] board;
      logic [N-1:0] pre;
      bit          is_step;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #200 clk = ~clk;

   life_engine_if #(.LOG_W(LOG_W), .LOG_H(LOG_H)) bus ();

   life_engine #(.LOG_W(LOG_W), .LOG_H(LOG_H)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t         sb_q[$];
   int           n_checks = 0;
   int           n_pass   = 0;
   bit           mon_busy = 1'b0;
   logic [N-1:0] m_board  = '0;
   logic [15:0]  m_gen    = '0;
   logic [AW:0]  m_pop    = '0;

   function automatic void chk(string name, logic [N-1:0] act, logic [N-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endfunction

   // Reference: count live neighbours per cell, then apply the B/S masks
   function automatic logic [N-1:0] life_step(input logic [N-1:0] b, input logic wr,
                                              input logic [8:0] bm, input logic [8:0] sm);
      logic [N-1:0] r;
      r = '0;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            int n;
            n = 0;
            for (int dy = -1; dy <= 1; dy++) begin
               for (int dx = -1; dx <= 1; dx++) begin
                  int xx, yy;
                  xx = x + dx;
                  yy = y + dy;
                  if (dx == 0 && dy == 0) continue;
                  if (wr) begin
                     xx = (xx + W) % W;
                     yy = (yy + H) % H;
                  end else if (xx < 0 || xx >= W || yy < 0 || yy >= H) begin
                     continue;
                  end
                  n += int'(b[yy*W + xx]);
               end
            end
            r[y*W + x] = b[y*W + x] ? sm[n] : bm[n];
         end
      end
      return r;
   endfunction

   task automatic read_board(output logic [N-1:0] b);
      for (int i = 0; i < N; i++) begin
         bus.rd_addr = AW'(i);
         #1;
         b[i] = bus.rd_data;
      end
   endtask

   task automatic write_cell(input int x, input int y, input logic d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(y*W + x);
      bus.wr_data = d;
      m_board[y*W + x] = d;
      @(posedge clk); #1;
      bus.wr_en = 1'b0;
   endtask

   task automatic issue(input logic [1:0] op, input logic wr, input logic [8:0] bm,
                        input logic [8:0] sm, input logic [N-1:0] rv, input bit hazard,
                        input bit same_wr, input int reset_at);
      exp_t e;
      int   cyc;
      int   a;
      if (same_wr) begin
         a = $urandom_range(0, N-1);
         bus.wr_en   = 1'b1;
         bus.wr_addr = AW'(a);
         bus.wr_data = ~m_board[a];
         m_board[a]  = ~m_board[a];
      end
      e.pre     = m_board;
      e.is_step = (op == 2'd2);
      case (op)
         2'd0: begin m_board = '0; m_gen = '0; e.len = N; end
         2'd1: begin m_board = rv; m_gen = '0; e.len = N; end
         2'd2: begin m_board = life_step(m_board, wr, bm, sm); m_gen = m_gen + 16'd1; e.len = 9*N + 1; end
         default: e.len = 0;
      endcase
      if (op != 2'd3) m_pop = (AW+1)'($countones(m_board));
      e.gen   = m_gen;
      e.pop   = m_pop;
      e.board = m_board;
      if (reset_at == 0) sb_q.push_back(e);

      bus.cmd_valid    = 1'b1;
      bus.cmd_op       = op;
      bus.wrap         = wr;
      bus.birth_mask   = bm;
      bus.survive_mask = sm;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      bus.wr_en     = 1'b0;
      if (op == 2'd1) begin
         for (int k = 0; k < N; k++) begin
            bus.rand_bit = rv[k];
            @(posedge clk); #1;
         end
      end

      if (reset_at > 0) begin
         repeat (reset_at) @(posedge clk);
         #1;
         reset   = 1'b1;
         m_board = '0;
         m_gen   = '0;
         m_pop   = '0;
         repeat (2) @(posedge clk);
         #1;
         reset = 1'b0;
         repeat (4) @(posedge clk);
         #1;
      end else begin
         cyc = 0;
         while ((sb_q.size() != 0 || mon_busy) && cyc < 9*N + 200) begin
            if (hazard && cyc == 50) begin
               bus.wr_en     = 1'b1;
               bus.wr_addr   = AW'($urandom_range(0, N-1));
               bus.wr_data   = 1'b1;
               bus.cmd_valid = 1'b1;
               bus.cmd_op    = 2'd0;
            end
            if (cyc == 51) begin
               bus.wr_en     = 1'b0;
               bus.cmd_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
         end
         bus.wr_en     = 1'b0;
         bus.cmd_valid = 1'b0;
         if (cyc >= 9*N + 200) begin
            n_checks++;
            $display("FAIL timeout: op %0d never completed, expected done within %0d cycles", op, 9*N + 200);
            sb_q.delete();
         end
      end
   endtask

   // Monitor: busy length, done pulse, status and full board at each completion
   initial begin : monitor
      exp_t         e;
      logic [N-1:0] b;
      int           busy_cnt;
      bit           chk_low;
      int           a;
      busy_cnt    = 0;
      chk_low     = 1'b0;
      bus.rd_addr = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            sb_q.delete();
            busy_cnt = 0;
            chk_low  = 1'b0;
         end else begin
            if (chk_low) begin
               chk("done_width", N'(bus.done), N'(0));
               chk_low = 1'b0;
            end
            if (bus.busy) begin
               busy_cnt++;
               if (busy_cnt == 100 && sb_q.size() != 0 && sb_q[0].is_step) begin
                  a = $urandom_range(0, N-1);
                  bus.rd_addr = AW'(a);
                  #1;
                  chk("rd_during_step", N'(bus.rd_data), N'(sb_q[0].pre[a]));
               end
            end else if (bus.done) begin
               mon_busy = 1'b1;
               chk_low  = 1'b1;
               if (sb_q.size() == 0) begin
                  chk("unexpected_done", N'(bus.done), N'(0));
               end else begin
                  e = sb_q.pop_front();
                  chk("busy_cycles", N'(busy_cnt), N'(e.len));
                  chk("generation", N'(bus.generation), N'(e.gen));
                  chk("pop_count", N'(bus.pop_count), N'(e.pop));
                  chk("cmd_ready", N'(bus.cmd_ready), N'(1));
                  read_board(b);
                  chk("board", b, e.board);
               end
               busy_cnt = 0;
               mon_busy = 1'b0;
            end
         end
      end
   end

   initial begin : stimulus
      logic [N-1:0] rv;
      logic [N-1:0] zero;
      zero = '0;
      bus.cmd_valid    = 1'b0;
      bus.cmd_op       = '0;
      bus.wrap         = 1'b0;
      bus.birth_mask   = '0;
      bus.survive_mask = '0;
      bus.rand_bit     = 1'b0;
      bus.wr_en        = 1'b0;
      bus.wr_addr      = '0;
      bus.wr_data      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Reserved op right after reset: status and board must be the reset state
      issue(2'd3, 1'b0, 9'h000, 9'h000, zero, 1'b0, 1'b0, 0);

      // Blinker
      write_cell(5, 3, 1'b1);
      write_cell(6, 3, 1'b1);
      write_cell(7, 3, 1'b1);
      issue(2'd2, 1'b0, 9'h008, 9'h00C, zero, 1'b0, 1'b0, 0);

      // Horizontal bar across the x seam, with and without wrap
      issue(2'd0, 1'b0, 9'h000, 9'h000, zero, 1'b0, 1'b0, 0);
      write_cell(15, 0, 1'b1);
      write_cell(0, 0, 1'b1);
      write_cell(1, 0, 1'b1);
      issue(2'd2, 1'b1, 9'h008, 9'h00C, zero, 1'b0, 1'b0, 0);
      issue(2'd0, 1'b0, 9'h000, 9'h000, zero, 1'b0, 1'b0, 0);
      write_cell(15, 0, 1'b1);
      write_cell(0, 0, 1'b1);
      write_cell(1, 0, 1'b1);
      issue(2'd2, 1'b0, 9'h008, 9'h00C, zero, 1'b0, 1'b0, 0);

      // Still-life block under B36/S23
      issue(2'd0, 1'b0, 9'h000, 9'h000, zero, 1'b0, 1'b0, 0);
      write_cell(3, 3, 1'b1);
      write_cell(4, 3, 1'b1);
      write_cell(3, 4, 1'b1);
      write_cell(4, 4, 1'b1);
      for (int s = 0; s < 3; s++) issue(2'd2, 1'b0, 9'h048, 9'h00C, zero, 1'b0, 1'b0, 0);

      // Full RANDOM then CLEAR
      issue(2'd1, 1'b0, 9'h000, 9'h000, ~zero, 1'b0, 1'b0, 0);
      issue(2'd0, 1'b0, 9'h000, 9'h000, zero, 1'b0, 1'b0, 0);

      // Random boards and rules, with edits and commands thrown at a busy engine
      for (int it = 0; it < 3; it++) begin
         for (int i = 0; i < N; i++) rv[i] = 1'($urandom_range(0, 1));
         issue(2'd1, 1'b0, 9'h000, 9'h000, rv, 1'b0, 1'b0, 0);
         write_cell($urandom_range(0, W-1), $urandom_range(0, H-1), 1'b1);
         issue(2'd2, 1'($urandom_range(0, 1)), 9'($urandom), 9'($urandom), zero, 1'b1, 1'b0, 0);
         issue(2'd2, 1'($urandom_range(0, 1)), 9'h008, 9'h00C, zero, 1'b1, 1'b0, 0);
         issue(2'd3, 1'b0, 9'h000, 9'h000, zero, 1'b0, 1'b0, 0);
      end

      // Edit on the same edge as a STEP accept joins that STEP
      issue(2'd2, 1'b1, 9'h008, 9'h00C, zero, 1'b0, 1'b1, 0);

      // Reset in the middle of a STEP, then confirm state and a clean STEP afterwards
      issue(2'd2, 1'b0, 9'h008, 9'h00C, zero, 1'b0, 1'b0, 500);
      issue(2'd3, 1'b0, 9'h000, 9'h000, zero, 1'b0, 1'b0, 0);
      write_cell(2, 2, 1'b1);
      write_cell(3, 2, 1'b1);
      write_cell(4, 2, 1'b1);
      issue(2'd2, 1'b1, 9'h008, 9'h00C, zero, 1'b0, 1'b0, 0);

      repeat (4) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/life_engine.md
LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 LOG_W, 4, log2 of board width W (W = 2**LOG_W).
REQ-002 LOG_H, 3, log2 of board height H; N = W*H cells; AW = LOG_W+LOG_H.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_op  in  2  0=CLEAR, 1=RANDOM, 2=STEP, 3=reserved (accepted, treated as no-op).
REQ-007 cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready.
REQ-008 wrap  in  1  1=toroidal board, 0=off-board neighbours read as dead; sampled at accept.
REQ-009 birth_mask / survive_mask  in  9 each  bit k set = birth/survival with k live neighbours; sampled at accept.
REQ-010 rand_bit  in  1  external random source for RANDOM.
REQ-011 rd_addr  in  AW / rd_data  out  1  combinational read of current bank, cell {y,x}.
REQ-012 wr_en  in  1 / wr_addr  in  AW / wr_data  in  1  single-cell edit of current bank.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 done  out  1  one-cycle pulse on command completion.
REQ-015 generation  out  16  generations since last CLEAR/RANDOM.
REQ-016 pop_count  out  AW+1  live cells at last command completion.

Function
REQ-017 Board held in two banks A/B of N flops; bank select cur selects the current bank; cell address = y*W + x.
REQ-018 States: IDLE, SEED, COUNT, COMMIT, FLIP; cmd_valid is ignored outside IDLE.
REQ-019 IDLE + accept CLEAR/RANDOM -> SEED, index 0; accept STEP -> COUNT, index 0, neighbour index 0, count 0; op 3 -> stays IDLE, done pulses next cycle.
REQ-020 SEED: one cell per cycle into current bank (0 for CLEAR, rand_bit for RANDOM); after cell N-1 -> IDLE; generation <- 0; pop_count <- cells written 1; busy for exactly N cycles.
REQ-021 COUNT: 8 cycles, neighbour order (-1,+1),(0,+1),(+1,+1),(-1,0),(+1,0),(-1,-1),(0,-1),(+1,-1); 4-bit count, no overflow possible.
REQ-022 Coordinates wrap modulo W/H when wrap=1; out-of-range neighbour contributes 0 when wrap=0.
REQ-023 COMMIT: next cell = alive ? survive_mask[count] : birth_mask[count], written to the non-current bank; live results accumulated; next cell -> COUNT, last cell -> FLIP.
REQ-024 FLIP: cur toggles, generation increments (wraps 0xFFFF->0), pop_count <- accumulated total, -> IDLE; STEP busy for exactly 9*N+1 cycles.
REQ-025 done pulses high in the first IDLE cycle after SEED or FLIP, for exactly one cycle.
REQ-026 During STEP, rd_data returns the pre-step board unchanged until FLIP; during SEED it returns in-progress contents.
REQ-027 wr_en honoured only in IDLE; ignored while busy; a write on the same edge as a STEP accept is included in that STEP; writes do not update pop_count.

Reset
REQ-028 reset: state IDLE, cur=A, both banks all 0, generation=0, pop_count=0, busy=0, done=0, cmd_ready=1 (after reset release); reset mid-command aborts it with no done pulse.

Verification
REQ-029 Blinker: write (5,3),(6,3),(7,3) on 16x8, B3/S23 (birth=0x008, survive=0x00C), STEP -> busy 1153 cycles, alive exactly (6,2),(6,3),(6,4), pop_count=3, generation=1, done one cycle.
REQ-030 Wrap: cells (15,0),(0,0),(1,0); wrap=1 STEP -> alive (0,7),(0,0),(0,1); repeat from same seed with wrap=0 -> board empty, pop_count=0.
REQ-031 Rule masks: single 2x2 block, birth=0x048 (B36), survive=0x00C -> block unchanged after 3 STEPs, generation=3, pop_count=4.
REQ-032 CLEAR after RANDOM with rand_bit=1: RANDOM -> pop_count=128, generation=0; CLEAR -> busy 128 cycles, all cells 0, pop_count=0.
REQ-033 Hazards: wr_en during STEP -> no change; cmd_valid during STEP -> ignored; rd_data during STEP shows pre-step board.
REQ-034 Reset mid-STEP at cycle 500 -> busy=0, all cells 0, generation=0, no done; next STEP completes normally.
